fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + hazard controller for the integer pipeline. Picks a bypass source
//  per EX operand across NUM_FWD later stages (stage 1 = youngest). Generates ID-stage stalls for
//  load-use hazards. Owns a scoreboard/FSM for one multi-cycle (mul/div) unit of MD_LAT cycles.
// PARAMETERS
//  NUM_SRC     2   source operands per instruction
//  NUM_FWD     2   bypass stages (1 = MEM, 2 = WB, ...)
//  RA_W        5   register address width; x0 is never forwarded, stalled on or scoreboarded
//  MD_LAT      4   multi-cycle unit latency in cycles, >= 2
//  SEL_W       $clog2(NUM_FWD+1) (derived) select width
// PORTS
//  clk          in   1               pipeline clock
//  rst_n        in   1               asynchronous, active-low reset
//  rs_ex        in   NUM_SRC*RA_W    EX source regs; src i at [i*RA_W +: RA_W]
//  rd_stg       in   NUM_FWD*RA_W    dest reg per bypass stage; stage k at [(k-1)*RA_W +: RA_W]
//  wr_stg       in   NUM_FWD         register-write enable per bypass stage
//  rs_id        in   NUM_SRC*RA_W    ID source regs
//  rs_used_id   in   NUM_SRC         ID source i is actually read
//  rd_id        in   RA_W            ID dest reg (WAW check)
//  wr_id        in   1               ID instruction writes rd_id
//  rd_ex        in   RA_W            EX dest reg
//  wr_ex        in   1               EX instruction writes rd_ex
//  is_load_ex   in   1               EX instruction is a load
//  md_start     in   1               issue op to multi-cycle unit this cycle (dest = rd_ex)
//  fwd_sel      out  NUM_SRC*SEL_W   0 = reg file, k = stage k
//  stall_id     out  1               hold IF/ID, bubble into EX
//  md_busy      out  1               multi-cycle unit occupied
//  md_wb_valid  out  1               1-cycle pulse: MD result writes md_wb_rd
//  md_wb_rd     out  RA_W            MD destination register
//  md_overrun   out  1               sticky: md_start while busy
//  stall_cnt    out  16              saturating count of stall_id cycles
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM IDLE, counter 0, md_busy/md_wb_valid/md_overrun 0, md_wb_rd 0,
//    stall_cnt 0. fwd_sel/stall_id combinational; with wr_*=0 and md_start=0 both read 0.
//  - fwd_sel[i] = smallest k with wr_stg[k] & rd_stg[k]==rs_ex[i] & rs_ex[i]!=0, else 0.
//    Youngest stage wins. Combinational, zero latency.
//  - load_use = is_load_ex & wr_ex & rd_ex!=0 & any i: rs_used_id[i] & rs_id[i]==rd_ex.
//  - md_hit = md_busy & md_wb_rd!=0 & (any i: rs_used_id[i] & rs_id[i]==md_wb_rd, or wr_id & rd_id==md_wb_rd).
//    This blocks RAW and WAW on the pending register.
//  - stall_id = load_use | md_hit | (md_busy & md_start).
//  - FSM IDLE: md_start -> BUSY. Latch md_wb_rd<=rd_ex, cnt<=MD_LAT-1, md_busy<=1 next cycle.
//  - FSM BUSY: cnt decrements each cycle. At cnt==1 -> DONE.
//  - FSM DONE (1 cycle): md_wb_valid=1, md_busy=1 -> IDLE. Pending register cleared on leaving DONE.
//    Timing: md_start at cycle T gives md_wb_valid at T+MD_LAT.
//  - md_start in DONE is accepted: DONE -> BUSY directly, reloading md_wb_rd/cnt (back-to-back).
//  - md_start in BUSY: ignored, no state change, md_overrun<=1 (cleared only by reset).
//  - md_start with rd_ex==0: op runs and times normally; md_hit never asserts.
//  - stall_cnt +1 on every cycle with stall_id=1; holds at 16'hFFFF.
//  - rst_n asserted mid-operation: in-flight MD op dropped, no md_wb_valid pulse.
// TESTING
//  - Priority: rs_ex={x5,x5}, rd_stg={x5,x5}, wr_stg=2'b11 -> fwd_sel={1,1}.
//    Then wr_stg=2'b10 -> {2,2}. Then rs_ex=x0 -> 0.
//  - Load-use: is_load_ex=1, wr_ex=1, rd_ex=x7, rs_id[1]=x7, rs_used_id=2'b10 -> stall_id=1.
//    Same with rs_used_id=2'b00 -> 0. Same with rd_ex=x0 -> 0.
//  - MD latency: MD_LAT=4, md_start at T0 with rd_ex=x9 -> md_busy T1..T4.
//    md_wb_valid=1 only at T4 with md_wb_rd=x9. ID reading x9 stalled T1..T4, released T5.
//  - Back-to-back: second md_start (rd_ex=x3) in DONE -> md_wb_valid at T4 and T8.
//    md_overrun stays 0.
//  - Overrun: md_start at T2 of a busy op -> ignored, stall_id=1 that cycle.
//    md_overrun=1 from T3 until reset. Original op still completes at T4.
//  - Reset mid-op + saturation: rst_n low at T2 -> all outputs 0 immediately, no wb pulse.
//    Hold load_use for 70000 cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use / multi-cycle hazard stall generation and a
// single-entry scoreboard for the multi-cycle (mul/div) unit.
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int RA_W    = 5,
    parameter int MD_LAT  = 4,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*RA_W-1:0]  rs_ex,
    input  logic [NUM_FWD*RA_W-1:0]  rd_stg,
    input  logic [NUM_FWD-1:0]       wr_stg,
    input  logic [NUM_SRC*RA_W-1:0]  rs_id,
    input  logic [NUM_SRC-1:0]       rs_used_id,
    input  logic [RA_W-1:0]          rd_id,
    input  logic                     wr_id,
    input  logic [RA_W-1:0]          rd_ex,
    input  logic                     wr_ex,
    input  logic                     is_load_ex,
    input  logic                     md_start,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall_id,
    output logic                     md_busy,
    output logic                     md_wb_valid,
    output logic [RA_W-1:0]          md_wb_rd,
    output logic                     md_overrun,
    output logic [15:0]              stall_cnt
);

    localparam int CNT_W = $clog2(MD_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    md_state_t                md_state_r;
    logic [CNT_W-1:0]         md_cnt_r;
    logic                     md_busy_r;
    logic                     md_wb_valid_r;
    logic [RA_W-1:0]          md_wb_rd_r;
    logic                     md_overrun_r;
    logic [15:0]              stall_cnt_r;

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
    logic                     load_use_s;
    logic                     md_ref_s;
    logic                     md_hit_s;
    logic                     stall_id_s;

    // Bypass select: scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        fwd_sel_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                if (wr_stg[k-1] && (rd_stg[(k-1)*RA_W +: RA_W] == rs_ex[i*RA_W +: RA_W])
                    && (rs_ex[i*RA_W +: RA_W] != '0)) begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
                end else begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = fwd_sel_s[i*SEL_W +: SEL_W];
                end
            end
        end
    end

    // ID-stage hazard detection: load-use, RAW/WAW against the pending MD register, MD issue conflict.
    always_comb begin
        load_use_s = 1'b0;
        md_ref_s   = wr_id && (rd_id == md_wb_rd_r);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_used_id[i] && (rs_id[i*RA_W +: RA_W] == rd_ex)) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
            if (rs_used_id[i] && (rs_id[i*RA_W +: RA_W] == md_wb_rd_r)) begin
                md_ref_s = 1'b1;
            end else begin
                md_ref_s = md_ref_s;
            end
        end
        load_use_s = load_use_s && is_load_ex && wr_ex && (rd_ex != '0);
        md_hit_s   = md_busy_r && (md_wb_rd_r != '0) && md_ref_s;
        stall_id_s = load_use_s || md_hit_s || (md_busy_r && md_start);
    end

    // Multi-cycle unit scoreboard; DONE accepts a new issue to allow back-to-back ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_r    <= ST_IDLE;
            md_cnt_r      <= '0;
            md_busy_r     <= 1'b0;
            md_wb_valid_r <= 1'b0;
            md_wb_rd_r    <= '0;
            md_overrun_r  <= 1'b0;
        end else begin
            case (md_state_r)
                ST_IDLE: begin
                    md_wb_valid_r <= 1'b0;
                    if (md_start) begin
                        md_state_r <= ST_BUSY;
                        md_wb_rd_r <= rd_ex;
                        md_cnt_r   <= CNT_W'(MD_LAT - 1);
                        md_busy_r  <= 1'b1;
                    end else begin
                        md_state_r <= ST_IDLE;
                        md_busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (md_start) begin
                        md_overrun_r <= 1'b1;
                    end else begin
                        md_overrun_r <= md_overrun_r;
                    end
                    if (md_cnt_r == CNT_W'(1)) begin
                        md_state_r    <= ST_DONE;
                        md_wb_valid_r <= 1'b1;
                    end else begin
                        md_cnt_r <= md_cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    md_wb_valid_r <= 1'b0;
                    if (md_start) begin
                        md_state_r <= ST_BUSY;
                        md_wb_rd_r <= rd_ex;
                        md_cnt_r   <= CNT_W'(MD_LAT - 1);
                        md_busy_r  <= 1'b1;
                    end else begin
                        md_state_r <= ST_IDLE;
                        md_wb_rd_r <= '0;
                        md_busy_r  <= 1'b0;
                    end
                end
                default: begin
                    md_state_r    <= ST_IDLE;
                    md_cnt_r      <= '0;
                    md_busy_r     <= 1'b0;
                    md_wb_valid_r <= 1'b0;
                    md_wb_rd_r    <= '0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_id_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign fwd_sel     = fwd_sel_s;
    assign stall_id    = stall_id_s;
    assign md_busy     = md_busy_r;
    assign md_wb_valid = md_wb_valid_r;
    assign md_wb_rd    = md_wb_rd_r;
    assign md_overrun  = md_overrun_r;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed and randomized checks of fwd_hazard_unit against a timeline-based
// reference model (MD op tracked by its issue cycle, not by FSM state).
module tb_fwd_hazard_unit;
    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int RA_W    = 5;
    localparam int MD_LAT  = 4;
    localparam int SEL_W   = $clog2(NUM_FWD + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_SRC*RA_W-1:0]  rs_ex, rs_id;
    logic [NUM_FWD*RA_W-1:0]  rd_stg;
    logic [NUM_FWD-1:0]       wr_stg;
    logic [NUM_SRC-1:0]       rs_used_id;
    logic [RA_W-1:0]          rd_id, rd_ex;
    logic                     wr_id, wr_ex, is_load_ex, md_start;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall_id, md_busy, md_wb_valid, md_overrun;
    logic [RA_W-1:0]          md_wb_rd;
    logic [15:0]              stall_cnt;

    fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .RA_W(RA_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .rs_ex(rs_ex), .rd_stg(rd_stg), .wr_stg(wr_stg),
        .rs_id(rs_id), .rs_used_id(rs_used_id), .rd_id(rd_id), .wr_id(wr_id),
        .rd_ex(rd_ex), .wr_ex(wr_ex), .is_load_ex(is_load_ex), .md_start(md_start),
        .fwd_sel(fwd_sel), .stall_id(stall_id), .md_busy(md_busy), .md_wb_valid(md_wb_valid),
        .md_wb_rd(md_wb_rd), .md_overrun(md_overrun), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the MD op is just "issued at cycle md_t0 into register m_rd".
    int            cyc    = 0;
    int            md_t0  = -1;
    logic [RA_W-1:0] m_rd = '0;
    bit            m_ovr  = 1'b0;
    int            m_scnt = 0;
    bit            e_stall = 1'b0;

    function automatic bit m_busy();
        return (md_t0 >= 0) && (cyc > md_t0) && (cyc <= md_t0 + MD_LAT);
    endfunction

    function automatic bit m_wbv();
        return (md_t0 >= 0) && (cyc == md_t0 + MD_LAT);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int hits[$];
        logic [NUM_SRC*SEL_W-1:0] esel;
        logic [RA_W-1:0] prd;
        bit lu, hit, busy;
        esel = '0;
        lu = 1'b0;
        busy = m_busy();
        prd = busy ? m_rd : '0;
        hit = wr_id && (rd_id == prd);
        for (int i = 0; i < NUM_SRC; i++) begin
            hits.delete();
            for (int k = 1; k <= NUM_FWD; k++)
                if (wr_stg[k-1] && rd_stg[(k-1)*RA_W +: RA_W] == rs_ex[i*RA_W +: RA_W]
                    && rs_ex[i*RA_W +: RA_W] != 0) hits.push_back(k);
            if (hits.size() > 0) esel[i*SEL_W +: SEL_W] = SEL_W'(hits[0]);
            if (rs_used_id[i] && rs_id[i*RA_W +: RA_W] == rd_ex) lu = 1'b1;
            if (rs_used_id[i] && rs_id[i*RA_W +: RA_W] == prd) hit = 1'b1;
        end
        lu = lu && is_load_ex && wr_ex && (rd_ex != 0);
        hit = hit && busy && (prd != 0);
        e_stall = lu || hit || (busy && md_start);
        chk({tag, "/fwd_sel"}, 32'(fwd_sel), 32'(esel));
        chk({tag, "/stall_id"}, 32'(stall_id), 32'(e_stall));
        chk({tag, "/md_busy"}, 32'(md_busy), 32'(busy));
        chk({tag, "/md_wb_valid"}, 32'(md_wb_valid), 32'(m_wbv()));
        chk({tag, "/md_wb_rd"}, 32'(md_wb_rd), 32'(prd));
        chk({tag, "/md_overrun"}, 32'(md_overrun), 32'(m_ovr));
        chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(m_scnt));
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (md_start) begin
            if (!m_busy() || m_wbv()) begin
                md_t0 = cyc;
                m_rd  = rd_ex;
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (e_stall && m_scnt < 65535) m_scnt++;
        cyc++;
        #1;
    endtask

    task automatic cyc_step(input string tag);
        settle();
        check_model(tag);
        tick();
    endtask

    task automatic clear_inputs();
        rs_ex = '0; rd_stg = '0; wr_stg = '0; rs_id = '0; rs_used_id = '0;
        rd_id = '0; wr_id = 1'b0; rd_ex = '0; wr_ex = 1'b0; is_load_ex = 1'b0; md_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "/fwd_sel"}, 32'(fwd_sel), 32'd0);
        chk({tag, "/stall_id"}, 32'(stall_id), 32'd0);
        chk({tag, "/md_busy"}, 32'(md_busy), 32'd0);
        chk({tag, "/md_wb_valid"}, 32'(md_wb_valid), 32'd0);
        chk({tag, "/md_wb_rd"}, 32'(md_wb_rd), 32'd0);
        chk({tag, "/md_overrun"}, 32'(md_overrun), 32'd0);
        chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_all_zero(tag);
        md_t0 = -1; m_ovr = 1'b0; m_scnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_inputs();
        #1;
        do_reset("reset");

        // Forwarding priority
        rs_ex = {5'd5, 5'd5}; rd_stg = {5'd5, 5'd5}; wr_stg = 2'b11;
        settle(); chk("fwd_youngest", 32'(fwd_sel), 32'h5); check_model("fwd_a"); tick();
        wr_stg = 2'b10;
        settle(); chk("fwd_stage2", 32'(fwd_sel), 32'hA); check_model("fwd_b"); tick();
        rs_ex = '0; rd_stg = '0;
        settle(); chk("fwd_x0", 32'(fwd_sel), 32'h0); check_model("fwd_c"); tick();
        clear_inputs();

        // Load-use
        is_load_ex = 1'b1; wr_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd2}; rs_used_id = 2'b10;
        settle(); chk("lu_hit", 32'(stall_id), 32'd1); check_model("lu_a"); tick();
        rs_used_id = 2'b00;
        settle(); chk("lu_unused", 32'(stall_id), 32'd0); check_model("lu_b"); tick();
        rs_used_id = 2'b10; rd_ex = 5'd0; rs_id = {5'd0, 5'd2};
        settle(); chk("lu_x0", 32'(stall_id), 32'd0); check_model("lu_c"); tick();
        clear_inputs();

        // MD latency and RAW stall on the pending register
        md_start = 1'b1; rd_ex = 5'd9;
        cyc_step("md_T0");
        md_start = 1'b0; rd_ex = 5'd0; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
        for (int t = 1; t <= 5; t++) begin
            settle();
            chk("md_busy_t", 32'(md_busy), 32'(t <= 4));
            chk("md_raw_stall_t", 32'(stall_id), 32'(t <= 4));
            chk("md_wbv_t", 32'(md_wb_valid), 32'(t == 4));
            if (t == 4) chk("md_wb_rd_t4", 32'(md_wb_rd), 32'd9);
            check_model("md_lat");
            tick();
        end
        clear_inputs();

        // Back-to-back issue accepted in the writeback cycle
        for (int t = 0; t <= 9; t++) begin
            md_start = (t == 0) || (t == 4);
            rd_ex = (t == 0) ? 5'd9 : ((t == 4) ? 5'd3 : 5'd0);
            settle();
            chk("b2b_wbv", 32'(md_wb_valid), 32'((t == 4) || (t == 8)));
            if (t == 4) chk("b2b_rd1", 32'(md_wb_rd), 32'd9);
            if (t == 8) chk("b2b_rd2", 32'(md_wb_rd), 32'd3);
            check_model("b2b");
            tick();
        end
        chk("b2b_no_overrun", 32'(md_overrun), 32'd0);
        clear_inputs();

        // Overrun: issue while busy is dropped and sticks the flag
        for (int t = 0; t <= 6; t++) begin
            md_start = (t == 0) || (t == 2);
            rd_ex = (t == 0) ? 5'd9 : ((t == 2) ? 5'd3 : 5'd0);
            settle();
            if (t == 2) chk("ovr_stall", 32'(stall_id), 32'd1);
            chk("ovr_flag", 32'(md_overrun), 32'(t >= 3));
            chk("ovr_wbv", 32'(md_wb_valid), 32'(t == 4));
            if (t == 4) chk("ovr_wb_rd", 32'(md_wb_rd), 32'd9);
            check_model("ovr");
            tick();
        end
        clear_inputs();

        // Randomized traffic with small register range to force collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rs_ex[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
                rs_id[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
            end
            for (int k = 0; k < NUM_FWD; k++) rd_stg[k*RA_W +: RA_W] = RA_W'($urandom_range(0, 3));
            wr_stg     = NUM_FWD'($urandom);
            rs_used_id = NUM_SRC'($urandom);
            rd_id      = RA_W'($urandom_range(0, 3));
            wr_id      = 1'($urandom);
            rd_ex      = RA_W'($urandom_range(0, 3));
            wr_ex      = 1'($urandom);
            is_load_ex = 1'($urandom);
            md_start   = ($urandom_range(0, 7) == 0);
            cyc_step("rnd");
        end
        clear_inputs();
        chk("ovr_sticky", 32'(md_overrun), 32'd1);

        // Reset in the middle of an MD op
        for (int n = 0; n < 6; n++) cyc_step("drain");
        md_start = 1'b1; rd_ex = 5'd9;
        cyc_step("rst_T0");
        md_start = 1'b0; rd_ex = 5'd0;
        cyc_step("rst_T1");
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        md_t0 = -1; m_ovr = 1'b0; m_scnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            settle();
            chk("rst_no_wb", 32'(md_wb_valid), 32'd0);
            check_model("post_rst");
            tick();
        end

        // Stall counter saturation under a held load-use hazard
        do_reset("reset_sat");
        is_load_ex = 1'b1; wr_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
        settle();
        chk("sat_stall", 32'(stall_id), 32'd1);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (70000 - 65534) @(posedge clk);
        #1;
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
